// File: rtl/mult_adder_index_unit.sv
// Shift-add multiplier helpers: 8-bit ripple adder, 4-bit index
// incrementer and the saturating iteration counter.

module mult_adder_index_inc (
   input  logic [3:0] i_val,
   output logic [3:0] o_val
);
   logic [4:0] w_c;

   assign w_c[0] = 1'b1;

   for (genvar i = 0; i < 4; i++) begin : g_ha
      assign o_val[i]  = i_val[i] ^ w_c[i];
      assign w_c[i+1]  = i_val[i] & w_c[i];
   end
endmodule

module mult_adder_index_unit (
   input  logic       clk,
   input  logic       res,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [8:0] sum,
   input  logic [3:0] index_in,
   output logic [3:0] next_index,
   input  logic       step,
   output logic [3:0] index,
   output logic       done
);
   logic [8:0] w_c;
   logic [3:0] w_index_inc;
   logic [3:0] r_index;

   assign w_c[0] = cin;

   for (genvar i = 0; i < 8; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign sum[8] = w_c[8];

   mult_adder_index_inc u_inc_ext (
      .i_val (index_in),
      .o_val (next_index)
   );

   mult_adder_index_inc u_inc_cnt (
      .i_val (r_index),
      .o_val (w_index_inc)
   );

   // Counter saturates at 8: done blocks further steps.
   always_ff @(posedge clk) begin
      if (res) begin
         r_index <= 4'd0;
      end else if (step && !r_index[3]) begin
         r_index <= w_index_inc;
      end
   end

   assign index = r_index;
   assign done  = r_index[3];
endmodule

// File: tb/tb_mult_adder_index_unit.sv
// Scoreboard bench for mult_adder_index_unit against an
// arithmetic reference model.

module tb_mult_adder_index_unit;
   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
   logic [8:0] sum;
   logic [3:0] index_in = '0;
   logic [3:0] next_index;
   logic       step = 1'b0;
   logic [3:0] index;
   logic       done;

   typedef struct {
      string   tag;
      int      e_sum;
      int      e_nxt;
      int      e_idx;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   m_idx  = -1;

   mult_adder_index_unit dut (
      .clk        (clk),
      .res        (res),
      .a          (a),
      .b          (b),
      .cin        (cin),
      .sum        (sum),
      .index_in   (index_in),
      .next_index (next_index),
      .step       (step),
      .index      (index),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic cyc(input string tag, input int av, input int bv,
                      input int cv, input int iv, input int sv,
                      input int rv);
      exp_t e;
      a = av[7:0];
      b = bv[7:0];
      cin = cv[0];
      index_in = iv[3:0];
      step = sv[0];
      res = rv[0];
      e.tag = tag;
      e.e_sum = av + bv + cv;
      e.e_nxt = (iv + 1) % 16;
      e.e_idx = m_idx;
      q.push_back(e);
      if (rv != 0) m_idx = 0;
      else if (m_idx >= 0 && sv != 0 && m_idx < 8) m_idx = m_idx + 1;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk({e.tag, "_sum"}, int'(sum), e.e_sum);
         chk({e.tag, "_next"}, int'(next_index), e.e_nxt);
         if (e.e_idx >= 0) begin
            chk({e.tag, "_index"}, int'(index), e.e_idx);
            chk({e.tag, "_done"}, int'(done), (e.e_idx >= 8) ? 1 : 0);
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;
      cyc("rst", 0, 0, 0, 0, 0, 1);
      cyc("rst_val", 0, 0, 0, 0, 0, 0);
      cyc("add_ff01", 8'hFF, 8'h01, 0, 0, 0, 0);
      cyc("add_ffff1", 8'hFF, 8'hFF, 1, 0, 0, 0);
      cyc("add_zero", 0, 0, 0, 0, 0, 0);
      cyc("add_sub", 8'h35, 8'hCA, 1, 0, 0, 0);
      for (int i = 0; i < 16; i++) cyc("inc", 0, 0, 0, i, 0, 0);
      cyc("run_rst", 0, 0, 0, 4'hF, 0, 1);
      for (int i = 0; i < 12; i++) cyc("run", 0, 0, 0, 7, 1, 0);
      cyc("run_hold", 0, 0, 0, 7, 0, 0);
      cyc("mid_rst0", 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cyc("mid_cnt", 0, 0, 0, 0, 1, 0);
      cyc("mid_rst", 0, 0, 0, 0, 1, 1);
      cyc("mid_after", 0, 0, 0, 0, 1, 0);
      cyc("mid_resume", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc("gate", 0, 0, 0, 0, (i % 2 == 0) ? 1 : 0, 0);
      cyc("gate_end", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10000; i++) begin
         cyc("rnd", int'($urandom_range(255)), int'($urandom_range(255)),
             int'($urandom_range(1)), int'($urandom_range(15)),
             int'($urandom_range(1)),
             ($urandom_range(40) == 0) ? 1 : 0);
      end
      cyc("tail", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
